fp16_to_fp32: RTL

Widening converter that turns an FP16 operand into an exactly equal FP32 result, with IEEE-754 exception flags carried alongside. It sits after the FP16 output path of the MAC datapath and returns narrowed results to full precision for accumulation or write-back. Normal, zero, Inf and NaN inputs convert in one cycle. Subnormal inputs are normalized by a multi-cycle shift FSM. Valid/ready handshakes apply on both sides.

---
 rtl/fp_pkg.sv | 31 +++
 rtl/fp16_classify.sv | 34 +++
 rtl/fp16_to_fp32.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared FP16/FP32 format constants, FSM state encoding and flag bundle
// for the floating-point widening path.
package fp_pkg;

   localparam int FP16_EXP_W  = 5;
   localparam int FP16_FRAC_W = 10;
   localparam int FP32_EXP_W  = 8;
   localparam int FP32_FRAC_W = 23;

   localparam int FP16_BIAS = 15;
   localparam int FP32_BIAS = 127;

   localparam logic [FP32_EXP_W-1:0] BIAS_DIFF    = 8'd112;
   // A subnormal that needs k shifts lands at exponent 113 - k.
   localparam logic [FP32_EXP_W-1:0] SUB_EXP_BASE = 8'd113;

   typedef enum logic [1:0] {
      IDLE,
      NORM,
      DONE
   } state_t;

   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } fp_flags_t;

endpackage

// File: rtl/fp16_classify.sv
// Purely combinational classification of a 16-bit FP16 operand.
module fp16_classify
   import fp_pkg::*;
(
   input  logic [15:0] operand,
   output logic        is_zero,
   output logic        is_sub,
   output logic        is_norm,
   output logic        is_inf,
   output logic        is_nan,
   output logic        is_snan
);

   logic [FP16_EXP_W-1:0]  exp_f;
   logic [FP16_FRAC_W-1:0] frac_f;
   logic                   exp_zero;
   logic                   exp_ones;
   logic                   frac_zero;

   assign exp_f     = operand[14:10];
   assign frac_f    = operand[9:0];
   assign exp_zero  = (exp_f == '0);
   assign exp_ones  = (exp_f == '1);
   assign frac_zero = (frac_f == '0);

   assign is_zero = exp_zero & frac_zero;
   assign is_sub  = exp_zero & ~frac_zero;
   assign is_norm = ~exp_zero & ~exp_ones;
   assign is_inf  = exp_ones & frac_zero;
   assign is_nan  = exp_ones & ~frac_zero;
   // Quiet bit clear marks a signalling NaN.
   assign is_snan = is_nan & ~frac_f[9];

endmodule

// File: rtl/fp16_to_fp32.sv
// FP16 -> FP32 widening converter with valid/ready handshakes; subnormals
// are normalised one bit per cycle by a small shift FSM.
module fp16_to_fp32
   import fp_pkg::*;
#(
   parameter int PARM_XLEN = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 mode,
   input  logic [PARM_XLEN-1:0] operand_i,
   input  logic                 NV_in,
   input  logic                 DZ_in,
   input  logic                 OF_in,
   input  logic                 UF_in,
   input  logic                 NX_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PARM_XLEN-1:0] result_o,
   output logic                 NV_out,
   output logic                 DZ_out,
   output logic                 OF_out,
   output logic                 UF_out,
   output logic                 NX_out
);

   state_t                 state, next_state;
   logic [10:0]            m;
   logic [3:0]             k;
   fp_flags_t              flags_q;
   fp_flags_t              flags_in;
   logic                   accept;
   logic                   go_norm;
   logic [10:0]            m_shift;
   logic [3:0]             k_inc;
   logic [PARM_XLEN-1:0]   fast_result;
   logic                   fast_nv;

   logic                   sgn;
   logic [FP16_EXP_W-1:0]  exp_h;
   logic [FP16_FRAC_W-1:0] frac_h;
   logic is_zero, is_sub, is_norm, is_inf, is_nan, is_snan;

   assign sgn    = operand_i[15];
   assign exp_h  = operand_i[14:10];
   assign frac_h = operand_i[9:0];

   fp16_classify u_classify (
      .operand (operand_i[15:0]),
      .is_zero (is_zero),
      .is_sub  (is_sub),
      .is_norm (is_norm),
      .is_inf  (is_inf),
      .is_nan  (is_nan),
      .is_snan (is_snan)
   );

   assign flags_in  = '{nv: NV_in, dz: DZ_in, of: OF_in, uf: UF_in, nx: NX_in};
   assign in_ready  = ~rst & ((state == IDLE) | ((state == DONE) & out_ready));
   assign out_valid = (state == DONE);
   assign accept    = in_valid & in_ready;
   assign go_norm   = mode & is_sub;
   assign m_shift   = {m[9:0], 1'b0};
   assign k_inc     = k + 4'd1;

   assign NV_out = flags_q.nv;
   assign DZ_out = flags_q.dz;
   assign OF_out = flags_q.of;
   assign UF_out = flags_q.uf;
   assign NX_out = flags_q.nx;

   // Single-cycle result for every class except subnormal.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      fast_result = '0;
      fast_nv     = NV_in;
      if (!mode) begin
         fast_result = operand_i;
      end else begin
         fast_nv = NV_in | is_snan;
         if (is_zero)
            fast_result = {sgn, 31'b0};
         else if (is_norm)
            fast_result = {sgn, {3'b000, exp_h} + BIAS_DIFF, frac_h, 13'b0};
         else if (is_inf)
            fast_result = {sgn, 8'hFF, 23'b0};
         else if (is_nan)
            fast_result = {sgn, 8'hFF, 1'b1, frac_h[8:0], 13'b0};
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (accept) next_state = go_norm ? NORM : DONE;
         NORM: if (m_shift[10]) next_state = DONE;
         DONE: begin
            if (out_ready) begin
               if (in_valid) next_state = go_norm ? NORM : DONE;
               else          next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: reset clears the shift register and counter too, so an aborted normalisation leaves nothing behind.
      if (rst) begin
         state    <= IDLE;
         result_o <= '0;
         flags_q  <= '0;
         m        <= '0;
         k        <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register update on the same edge snapshot.
         state <= next_state;
         if (accept) begin
            flags_q  <= '{nv: fast_nv, dz: flags_in.dz, of: flags_in.of,
                          uf: flags_in.uf, nx: flags_in.nx};
            result_o <= go_norm ? {sgn, 31'b0} : fast_result;
            if (go_norm) begin
               m <= {1'b0, frac_h};
               k <= '0;
            end
         end else if (state == NORM) begin
            m <= m_shift;
            k <= k_inc;
            // Sign was parked in bit 31 at capture; fill in exponent and fraction.
            if (m_shift[10])
               result_o[30:0] <= {SUB_EXP_BASE - {4'b0000, k_inc}, m_shift[9:0], 13'b0};
         end
      end
   end

endmodule
